etr_conditioner: RTL and testbench
==================================

Name: etr_conditioner

Overview:
- Conditions the timer's external trigger input (ETR) into a one-cycle trigger pulse for the counter core.
- Chain: 2-flop synchronizer → polarity select → digital glitch filter → rising-edge detector → edge prescaler.
- Sits between the ETR pad and the counter core's external-clock and trigger inputs.
- Configured by control-register fields ece/etp/etf/etps.

Parameters:
- SYNC_STAGES, 2, synchronizer depth; legal values 2..3.

Ports:
- clk_i  input  1  system clock
- srst_i  input  1  synchronous reset, active-high
- etr_i  input  1  asynchronous external trigger pin
- ece_i  input  1  external trigger enable
- etp_i  input  1  polarity: 0 = active-high/rising, 1 = inverted/falling
- etf_i  input  4  filter select; 0 = filter off
- etps_i  input  2  edge prescaler: 00 = /1, 01 = /2, 10 = /4, 11 = /8
- etrf_o  output  1  filtered, polarity-adjusted ETR level
- trig_o  output  1  one-cycle trigger pulse after prescaling

Behaviour:
- Reset (srst_i=1 at a clk_i edge): clear synchronizer flops, etrf_o, edge-history bit, sample counter, match counter, prescaler counter and registered config copies. trig_o=0. srst_i takes priority over everything.
- Synchronizer:
  - etr_i → SYNC_STAGES flops → s.
  - p = s XOR etp_i.
- Filter off (etf_i=0):
  - etrf_o <= p every cycle.
  - Latency: etr_i change set up before edge 0 → etrf_o updates after edge SYNC_STAGES.
- Filter on:
  - Sample divider D = 2^etf_i[3:2], giving 1/2/4/8.
  - Required count N = {2,4,6,8}[etf_i[1:0]].
  - 3-bit sample counter produces tick when it reaches D-1, then wraps to 0. D=1 ticks every cycle.
  - On tick, if p != etrf_o: match counter +1. When the incremented value equals N, toggle etrf_o and clear the match counter.
  - On tick, if p == etrf_o: clear the match counter (glitch rejected).
  - No tick: hold state.
- Edge detect:
  - Registered history bit h <= etrf_o.
  - Rising edge = etrf_o & ~h.
- Prescaler:
  - P = 2^etps_i.
  - On a rising edge: if cnt == P-1, then trig_o=1 for exactly the next cycle and cnt <= 0; else cnt+1.
  - trig_o is registered. With filter off and /1, it is high for the single cycle following edge SYNC_STAGES+1.
- Disable (ece_i=0):
  - etrf_o <= p and h <= p directly (filter bypassed, history tracks level).
  - Sample, match and prescaler counters held at 0.
  - trig_o=0.
- Enable (ece_i 0→1) while the level is already high: no trigger pulse. The first pulse requires a genuine rising edge. The first output occurs on the P-th edge after enable.
- Config change (etf_i, etps_i or etp_i differs from its registered copy while ece_i=1):
  - That cycle, clear the sample, match and prescaler counters.
  - Load etrf_o <= p and h <= p.
  - Force trig_o=0 next cycle.
  - Update the registered copies.
  - A polarity flip therefore never creates a spurious edge.
- Simultaneous events:
  - Config change or ece_i=0 overrides a coincident filter toggle or prescaler wrap.
  - An edge arriving while trig_o is high is counted normally.
- Widths: sample counter 3 bits, match counter 4 bits, prescaler 3 bits. No counter ever exceeds its limit. If etf_i changes mid-count, the config-change clear makes stale larger counts impossible.
- Reset mid-operation: all state returns to reset values in the same cycle. No pulse is emitted on the following cycle.

Test Plan:
- Reset:
  - Stimulus: srst_i=1 for 3 cycles with etr_i toggling.
  - Required: etrf_o=0 and trig_o=0 throughout, and on the first cycle after release.
- Filter off, /1, etp=0:
  - Stimulus: etr_i rises before edge 0.
  - Required: etrf_o=1 after edge 2; trig_o=1 only between edge 3 and edge 4.
  - Stimulus: 5 rising pulses.
  - Required: 5 trig_o pulses.
- Filter etf=4'b0101 (D=2, N=4):
  - Stimulus: 5-cycle-high glitch.
  - Required: etrf_o stays 0, no trig_o.
  - Stimulus: sustained high.
  - Required: etrf_o rises on the 4th qualifying tick, about 8 cycles after sync; exactly one trig_o.
- Prescaler etps=2'b10:
  - Stimulus: 12 clean rising edges.
  - Required: trig_o after the 4th, 8th and 12th edges only; 3 pulses total.
- Polarity and config:
  - Stimulus: etr_i held high, ece=1; flip etp_i 0→1.
  - Required: etrf_o goes 0 with no trig_o.
  - Stimulus: etr_i falls.
  - Required: one trig_o.
  - Stimulus: change etps_i mid-count (after 2 of 4 edges).
  - Required: count restarts; the next pulse needs a full P edges under the new setting.
- Enable while high:
  - Stimulus: etr_i=1 steady, ece_i 0→1.
  - Required: no trig_o.
  - Stimulus: etr_i low then high.
  - Required: exactly one pulse.
  - Stimulus: ece_i=0 mid-prescale, then re-enable.
  - Required: prescaler restarts from 0.

Source files
------------

// File: rtl/etr_conditioner.sv
// etr_conditioner: ETR synchronizer, polarity select, glitch filter, rising-edge detect and edge prescaler
module etr_conditioner #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       srst_i,
  input  logic       etr_i,
  input  logic       ece_i,
  input  logic       etp_i,
  input  logic [3:0] etf_i,
  input  logic [1:0] etps_i,
  output logic       etrf_o,
  output logic       trig_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [3:0] etf_q, mat_q, mat_d, n_req, mat_inc;
  logic [1:0] etps_q;
  logic [2:0] smp_q, smp_d, psc_q, psc_d, d_max, p_max;
  logic       etp_q, h_q, h_d, etrf_d, trig_d, p, cfg_chg, tick, edge_det, hit;
  assign p        = sync_q[SYNC_STAGES-1] ^ etp_i;
  assign cfg_chg  = (etf_i != etf_q) || (etps_i != etps_q) || (etp_i != etp_q);
  assign d_max    = 3'((4'd1 << etf_i[3:2]) - 4'd1);
  assign p_max    = 3'((4'd1 << etps_i) - 4'd1);
  assign n_req    = {1'b0, etf_i[1:0], 1'b0} + 4'd2;
  assign tick     = smp_q == d_max;
  assign mat_inc  = mat_q + 4'd1;
  assign hit      = tick && (p != etrf_o) && (mat_inc == n_req);
  assign edge_det = etrf_o & ~h_q;
  // Disable and config change both resync the level so no spurious edge appears
  always_comb begin
    etrf_d = etrf_o;
    h_d    = etrf_o;
    smp_d  = smp_q;
    mat_d  = mat_q;
    psc_d  = psc_q;
    trig_d = 1'b0;
    if (!ece_i || cfg_chg) begin
      etrf_d = p;
      h_d    = p;
      smp_d  = 3'd0;
      mat_d  = 4'd0;
      psc_d  = 3'd0;
    end else begin
      if (etf_i == 4'd0) begin
        etrf_d = p;
      end else begin
        smp_d  = tick ? 3'd0 : smp_q + 3'd1;
        mat_d  = !tick ? mat_q : ((p == etrf_o) || hit) ? 4'd0 : mat_inc;
        etrf_d = hit ? ~etrf_o : etrf_o;
      end
      if (edge_det) begin
        psc_d  = (psc_q == p_max) ? 3'd0 : psc_q + 3'd1;
        trig_d = psc_q == p_max;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      sync_q <= '0;
      etrf_o <= 1'b0;
      h_q    <= 1'b0;
      smp_q  <= 3'd0;
      mat_q  <= 4'd0;
      psc_q  <= 3'd0;
      trig_o <= 1'b0;
      etf_q  <= 4'd0;
      etps_q <= 2'd0;
      etp_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], etr_i};
      etrf_o <= etrf_d;
      h_q    <= h_d;
      smp_q  <= smp_d;
      mat_q  <= mat_d;
      psc_q  <= psc_d;
      trig_o <= trig_d;
      etf_q  <= etf_i;
      etps_q <= etps_i;
      etp_q  <= etp_i;
    end
  end
endmodule

// File: tb/tb_etr_conditioner.sv
// tb_etr_conditioner: scoreboard bench; expected trigger cycles are queued as edges are driven
module tb_etr_conditioner;
  logic       clk = 1'b0, srst = 1'b1, etr = 1'b0, ece = 1'b0, etp = 1'b0;
  logic [3:0] etf = 4'd0;
  logic [1:0] etps = 2'd0;
  logic       etrf, trig;
  int cyc = 0, n_cmp = 0, n_err = 0, edges = 0, pdiv = 1, n_trig = 0;
  int exp_q[$];

  etr_conditioner #(.SYNC_STAGES(2)) dut (
    .clk_i(clk), .srst_i(srst), .etr_i(etr), .ece_i(ece), .etp_i(etp),
    .etf_i(etf), .etps_i(etps), .etrf_o(etrf), .trig_o(trig)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_err++;
      $display("FAIL %s: got %0d, wanted %0d (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (trig === 1'b1) begin
      n_trig++;
      if (exp_q.size() == 0) chk("spurious_trig_cycle", cyc, -1);
      else chk("trig_cycle", cyc, exp_q.pop_front());
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean pulse with filter off: trigger lands 4 cycles after the drive when the prescaler wraps
  task automatic rise(input int hi, input int lo);
    etr = 1'b1;
    edges++;
    if (edges % pdiv == 0) exp_q.push_back(cyc + 4);
    step(hi);
    etr = 1'b0;
    step(lo);
  endtask

  task automatic set_div(input logic [1:0] v);
    etps = v;
    pdiv = 1 << v;
    edges = 0;
    step(3);
  endtask

  task automatic drain(input string tag);
    step(8);
    chk(tag, exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c, t1, c0, base;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      etr = ~etr;
      chk("rst_etrf", etrf, 0);
      chk("rst_trig", trig, 0);
    end
    etr = 1'b0;
    srst = 1'b0;
    step(1);
    chk("post_rst_etrf", etrf, 0);
    chk("post_rst_trig", trig, 0);
    ece = 1'b1;
    step(4);
    // filter off, /1: latency of level and pulse
    c = cyc;
    etr = 1'b1;
    exp_q.push_back(c + 4);
    step(2);
    chk("off_etrf_before_edge2", etrf, 0);
    step(1);
    chk("off_etrf_after_edge2", etrf, 1);
    step(2);
    etr = 1'b0;
    step(3);
    for (int i = 0; i < 5; i++) rise(2, 3);
    drain("off_div1_pending");
    // filter D=2, N=4: glitch rejected, sustained level accepted
    etf = 4'b0101;
    c0 = cyc;
    step(4);
    for (int i = 0; i < 20; i++) begin
      etr = (i < 5);
      step(1);
      chk("glitch_etrf", etrf, 0);
    end
    c = cyc;
    etr = 1'b1;
    t1 = c + 3;
    if ((t1 - c0) % 2 == 0) t1++;
    exp_q.push_back(t1 + 7);
    step(t1 + 5 - c);
    chk("filt_etrf_pre", etrf, 0);
    step(1);
    chk("filt_etrf_rise", etrf, 1);
    step(6);
    drain("filter_pending");
    etf = 4'd0;
    step(3);
    etr = 1'b0;
    step(5);
    drain("filter_exit_pending");
    // prescaler /4
    set_div(2'b10);
    base = n_trig;
    for (int i = 0; i < 12; i++) rise(2, 2);
    drain("div4_pending");
    chk("div4_pulse_count", n_trig - base, 3);
    // polarity flip while high gives no edge; the falling pin then triggers
    set_div(2'b00);
    etr = 1'b1;
    exp_q.push_back(cyc + 4);
    step(8);
    drain("pol_setup_pending");
    etp = 1'b1;
    step(3);
    chk("pol_flip_etrf", etrf, 0);
    drain("pol_flip_pending");
    etr = 1'b0;
    exp_q.push_back(cyc + 4);
    step(8);
    chk("pol_fall_etrf", etrf, 1);
    drain("pol_fall_pending");
    etp = 1'b0;
    step(4);
    chk("pol_restore_etrf", etrf, 0);
    drain("pol_restore_pending");
    // prescaler change mid-count restarts the count
    set_div(2'b10);
    rise(2, 2);
    rise(2, 2);
    set_div(2'b01);
    rise(2, 2);
    rise(2, 2);
    drain("div_change_pending");
    // enable while the level is already high
    set_div(2'b00);
    ece = 1'b0;
    etr = 1'b1;
    step(6);
    ece = 1'b1;
    step(8);
    chk("en_high_etrf", etrf, 1);
    drain("en_high_pending");
    etr = 1'b0;
    step(4);
    rise(2, 3);
    drain("en_first_pending");
    // disable mid-prescale clears the count
    set_div(2'b10);
    rise(2, 2);
    rise(2, 2);
    ece = 1'b0;
    step(4);
    ece = 1'b1;
    step(2);
    edges = 0;
    for (int i = 0; i < 4; i++) rise(2, 2);
    drain("en_restart_pending");
    // reset just before a pulse would be registered
    set_div(2'b00);
    c = cyc;
    etr = 1'b1;
    step(3);
    srst = 1'b1;
    step(1);
    chk("rst_mid_etrf", etrf, 0);
    srst = 1'b0;
    exp_q.push_back(cyc + 4);
    step(8);
    chk("rst_mid_etrf_after", etrf, 1);
    drain("rst_mid_pending");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
